// File: rtl/alu_arbiter.sv
//==============================================================================
// alu_arbiter: two-requester front end sharing one combinational ALU.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grant (else fixed priority to 0).
// Revision: 1.0
//==============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_srca,
  input  logic [WIDTH-1:0] req0_srcb,
  input  logic [WIDTH-1:0] req1_srca,
  input  logic [WIDTH-1:0] req1_srcb,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp0_zero,
  output logic             rsp1_zero,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [2:0]       alu_alucontrol,
  input  logic [WIDTH-1:0] alu_aluout,
  input  logic             alu_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_gid;

  logic             w_grant;
  logic             w_any_req;
  logic             w_idle;
  logic             w_accept;
  logic             w_rsp_take;

  assign w_any_req = req0_valid | req1_valid;
  assign w_idle    = (r_state == IDLE) & ~reset;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic r_last;

  // On contention, hand the grant to whichever id did not win last time.
  always_comb begin
    if (req0_valid && req1_valid) w_grant = ~r_last;
    else                          w_grant = ~req0_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last <= 1'b1;
    else if (w_accept) r_last <= w_grant;
  end
`else
  assign w_grant = ~req0_valid;
`endif

  assign req0_ready = w_idle & w_any_req & ~w_grant;
  assign req1_ready = w_idle & w_any_req &  w_grant;
  assign w_accept   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_rsp_take = r_gid ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_op     <= 3'd0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_gid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_srca  <= w_grant ? req1_srca : req0_srca;
            r_srcb  <= w_grant ? req1_srcb : req0_srcb;
            r_op    <= w_grant ? req1_op   : req0_op;
            r_gid   <= w_grant;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_result <= alu_aluout;
          r_zero   <= alu_zero;
          r_state  <= RESP;
        end
        RESP: begin
          if (w_rsp_take) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_srca       = r_srca;
  assign alu_srcb       = r_srcb;
  assign alu_alucontrol = r_op;

  // Both responders share one result register; only the valid qualifies it.
  assign rsp0_valid  = ~reset & (r_state == RESP) & ~r_gid;
  assign rsp1_valid  = ~reset & (r_state == RESP) &  r_gid;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_zero   = r_zero;
  assign rsp1_zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
//==============================================================================
// tb_alu_arbiter: directed checks of the ALU arbiter with a behavioural ALU.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [2:0]       req0_op, req1_op;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [WIDTH-1:0] alu_srca, alu_srcb;
  logic [2:0]       alu_alucontrol;
  logic [WIDTH-1:0] alu_aluout;
  logic             alu_zero;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb),
    .req0_op(req0_op), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_alucontrol(alu_alucontrol),
    .alu_aluout(alu_aluout), .alu_zero(alu_zero)
  );

  // Behavioural shared ALU
  always_comb begin
    case (alu_alucontrol)
      3'b000:  alu_aluout = alu_srca & alu_srcb;
      3'b001:  alu_aluout = alu_srca | alu_srcb;
      3'b010:  alu_aluout = alu_srca + alu_srcb;
      3'b101:  alu_aluout = alu_srca & ~alu_srcb;
      3'b110:  alu_aluout = alu_srca - alu_srcb;
      3'b111:  alu_aluout = ($signed(alu_srca) < $signed(alu_srcb)) ? 32'd1 : 32'd0;
      default: alu_aluout = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_aluout == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic exp_gid;
  logic [31:0] exp_res;

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_srca = '0; req0_srcb = '0; req1_srca = '0; req1_srcb = '0;
    req0_op = 3'd0; req1_op = 3'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset: outputs quiet even with requests pending
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("rst_alu_srca", alu_srca, 32'd0);
    check("rst_alu_ctrl", {29'd0, alu_alucontrol}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;

    // Req0 ADD 5 + 7
    @(negedge clk);
    req0_valid = 1'b1; req0_srca = 32'd5; req0_srcb = 32'd7; req0_op = 3'b010;
    #1;
    check("add_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("add_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    check("add_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("add_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    check("add_alu_srca", alu_srca, 32'd5);
    check("add_alu_ctrl", {29'd0, alu_alucontrol}, 32'd2);
    @(negedge clk);
    check("add_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("add_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check("add_result", rsp0_result, 32'd12);
    check("add_zero", {31'd0, rsp0_zero}, 32'd0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    check("add_done_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);

    // Req1 SUB 9 - 9
    req1_valid = 1'b1; req1_srca = 32'd9; req1_srcb = 32'd9; req1_op = 3'b110;
    #1;
    check("sub_req1_ready", {31'd0, req1_ready}, 32'd1);
    check("sub_req0_ready", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("sub_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("sub_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("sub_result", rsp1_result, 32'd0);
    check("sub_zero", {31'd0, rsp1_zero}, 32'd1);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    check("sub_done_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);

    // Contention: port0 AND, port1 SLT -3 < 2, responses consumed at once
    req0_valid = 1'b1; req0_srca = 32'h0000_FF00; req0_srcb = 32'h0000_0FF0; req0_op = 3'b000;
    req1_valid = 1'b1; req1_srca = 32'hFFFF_FFFD; req1_srcb = 32'd2; req1_op = 3'b111;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_gid = g[0];
`else
      exp_gid = 1'b0;
`endif
      exp_res = exp_gid ? 32'd1 : 32'h0000_0F00;
      #1;
      check($sformatf("arb%0d_req0_ready", g), {31'd0, req0_ready}, {31'd0, ~exp_gid});
      check($sformatf("arb%0d_req1_ready", g), {31'd0, req1_ready}, {31'd0, exp_gid});
      @(negedge clk);
      check($sformatf("arb%0d_exec_req1_ready", g), {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      check($sformatf("arb%0d_rsp0_valid", g), {31'd0, rsp0_valid}, {31'd0, ~exp_gid});
      check($sformatf("arb%0d_rsp1_valid", g), {31'd0, rsp1_valid}, {31'd0, exp_gid});
      check($sformatf("arb%0d_result", g), exp_gid ? rsp1_result : rsp0_result, exp_res);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);

    // Back-pressure: rsp0 held 5 cycles, req1 waits
    req0_valid = 1'b1; req0_srca = 32'd100; req0_srcb = 32'd23; req0_op = 3'b010;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_srca = 32'd3; req1_srcb = 32'd4; req1_op = 3'b001;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rsp0_valid", c), {31'd0, rsp0_valid}, 32'd1);
      check($sformatf("bp%0d_result", c), rsp0_result, 32'd123);
      check($sformatf("bp%0d_req1_ready", c), {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp_done_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
    check("bp_rsp1_result", rsp1_result, 32'd7);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_srca = 32'hF0; req0_srcb = 32'h0F; req0_op = 3'b001;
    @(negedge clk);
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_rsp0_valid_in_reset", {31'd0, rsp0_valid}, 32'd0);
    check("abort_alu_srca", alu_srca, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rsp0_valid_a", {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk);
    check("abort_rsp0_valid_b", {31'd0, rsp0_valid}, 32'd0);
    check("abort_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_srca = 32'd1; req1_srcb = 32'd1; req1_op = 3'b010;
    #1;
    check("post_rst_req0_ready", {31'd0, req0_ready}, 32'd1);
    check("post_rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    check("post_rst_result", rsp0_result, 32'hFF);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
